seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 7-segment display drivers.
//  - Watches a multiplexed 4-digit common-anode bus (active-low anodes, active-low segments).
//  - Waits for each digit to settle, then decodes its segment pattern back to BCD.
//  - Presents all four digits as a 16-bit word.
//  - Used as an on-board loopback monitor and as a bench checker for the display path.
// PARAMETERS
//  SETTLE_CYCLES   4      consecutive stable cycles (anode+seg) required before a capture; >=1
//  TIMEOUT_CYCLES  1000   cycles with no capture before all captured state is invalidated
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  anode_in     in   4   digit enables, active-low, one-hot-low when valid (bit0 = rightmost digit)
//  seg_in       in   7   segments, active-low, bit0=a ... bit6=g
//  dp_in        in   1   decimal point, active-low
//  digits       out  16  BCD digits, digits[4k+3:4k] = digit k
//  digit_valid  out  4   digit k holds a valid decode since the last clear
//  frame_valid  out  1   all four digit_valid bits set
//  strobe       out  1   1-cycle pulse on every capture
//  seg_err      out  1   1-cycle pulse when a captured pattern is not 0-9
//  dp_out       out  4   captured decimal point per digit, active-high
// BEHAVIOUR
//  Reset values
//   - digits=16'hFFFF; digit_valid=0; frame_valid=0; strobe=0; seg_err=0; dp_out=0; FSM=IDLE.
//  Input registration
//   - anode_in, seg_in, dp_in are registered once (anode_q, seg_q, dp_q).
//   - All decisions use the registered values.
//  FSM
//   - IDLE: anode_q not exactly one bit low -> stay. Exactly one bit low -> SETTLE, cnt=1.
//   - SETTLE: anode_q and seg_q both equal to the previous cycle -> cnt++.
//       - Any change while still one-hot -> restart, cnt=1.
//       - Not one-hot -> IDLE.
//       - cnt reaching SETTLE_CYCLES -> capture this cycle, then HOLD.
//   - HOLD: stay while anode_q is unchanged; seg changes within HOLD are ignored.
//       - anode_q changes to another one-hot value -> SETTLE, cnt=1.
//       - anode_q changes to a non-one-hot value -> IDLE.
//   - An anode change on the same cycle the count would complete wins: no capture.
//  Capture
//   - Outputs update the cycle after the capture decision; strobe pulses in that same cycle.
//   - Total latency is SETTLE_CYCLES+1 cycles from the first registered stable cycle.
//   - Valid codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
//   - Valid code: digits[k] = value; digit_valid[k] set.
//   - Any other code: digits[k] = 4'hF; digit_valid[k] cleared; seg_err pulses with strobe.
//   - frame_valid = &digit_valid, registered with the same timing as digit_valid.
//  Timeout
//   - 32-bit counter cleared on every capture, saturating at TIMEOUT_CYCLES.
//   - On reaching TIMEOUT_CYCLES: digit_valid=0, frame_valid=0, digits=16'hFFFF; dp_out unchanged.
//   - A capture and a timeout in the same cycle: capture wins and the counter clears.
//  Reset mid-settle or mid-hold
//   - Everything returns to reset values; no strobe in the cycle rst is high.
// CONFIGURATION
//  DP_CAPTURE_EN
//   - Defined: dp_out[k] = ~dp_q, captured with digit k; included in the stability check.
//   - Undefined: dp_in is ignored; dp_out is tied 4'b0000.
// TESTING
//  1. rst for 2 cycles, then anode_in=4'b1110 and seg_in=7'h24 held 10 cycles
//     -> single strobe; digits[3:0]=2; digit_valid=4'b0001; frame_valid=0.
//  2. Scan digits 0..3 with 9,0,4,7 (each held 8 cycles)
//     -> digits=16'h7409; frame_valid=1 after the 4th strobe; no seg_err.
//  3. anode_in=4'b1101 with seg_in toggling 7'h79/7'h24 every 2 cycles (SETTLE_CYCLES=4)
//     -> no strobe; then hold 7'h79 -> strobe; digits[7:4]=1.
//  4. seg_in=7'h7F on digit 2 after a full frame
//     -> seg_err and strobe together; digits[11:8]=F; digit_valid[2]=0; frame_valid=0.
//  5. anode_in=4'b1111 for TIMEOUT_CYCLES after a full frame
//     -> digit_valid=0; digits=16'hFFFF; no strobe.
//  6. rst asserted on the 3rd settle cycle
//     -> no strobe; all outputs at reset values the next cycle.
//     With DP_CAPTURE_EN: dp_in=0 on digit 1 -> dp_out=4'b0010.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for seg7_scan_decoder: multiplexed display bus in, decoded digits out.
// master = display side / checker, slave = decoder.
interface seg7_scan_decoder_if;
  logic [3:0]  anode_in;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        strobe;
  logic        seg_err;
  logic [3:0]  dp_out;

  modport master (
    output anode_in, seg_in, dp_in,
    input  digits, digit_valid, frame_valid, strobe, seg_err, dp_out
  );

  modport slave (
    input  anode_in, seg_in, dp_in,
    output digits, digit_valid, frame_valid, strobe, seg_err, dp_out
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a 4-digit multiplexed common-anode bus and decodes each settled digit back to BCD.
// Optional: define DP_CAPTURE_EN to capture the decimal point per digit and include it in the settle check.

module seg7_digit_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic       ok,
  input  logic [3:0] val,
  input  logic       dp,
  output logic [3:0] digit,
  output logic       valid,
  output logic       valid_nxt,
  output logic       dp_cap
);
  // A capture beats a same-cycle timeout flush.
  always_comb begin
    valid_nxt = valid;
    if (load)       valid_nxt = ok;
    else if (flush) valid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit  <= 4'hF;
      valid  <= 1'b0;
      dp_cap <= 1'b0;
    end else begin
      valid <= valid_nxt;
      if (load) begin
        digit  <= ok ? val : 4'hF;
        dp_cap <= dp;
      end else if (flush) begin
        digit  <= 4'hF;
      end
    end
  end
endmodule

module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);
  localparam int              NUM_LANES = 4;
  localparam int              CW        = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [31:0]     TMO       = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [3:0]    anode_q, anode_p;
  logic [6:0]    seg_q, seg_p;
  logic          lane_dp;
  logic          stable;
  logic          oh;
  logic [1:0]    idx;
  logic          ok;
  logic [3:0]    val;
  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          cap, start;
  logic [31:0]   tcnt, tcnt_d;
  logic          flush;
  logic          strobe_r, seg_err_r, frame_r;

  logic [NUM_LANES-1:0][3:0] dig;
  logic [NUM_LANES-1:0]      vld, vld_nxt, dpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q <= 4'hF;
      anode_p <= 4'hF;
      seg_q   <= 7'h7F;
      seg_p   <= 7'h7F;
    end else begin
      anode_q <= bus.anode_in;
      anode_p <= anode_q;
      seg_q   <= bus.seg_in;
      seg_p   <= seg_q;
    end
  end

`ifdef DP_CAPTURE_EN
  logic dp_q, dp_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q <= 1'b1;
      dp_p <= 1'b1;
    end else begin
      dp_q <= bus.dp_in;
      dp_p <= dp_q;
    end
  end

  assign stable  = (anode_q == anode_p) && (seg_q == seg_p) && (dp_q == dp_p);
  assign lane_dp = ~dp_q;
`else
  assign stable  = (anode_q == anode_p) && (seg_q == seg_p);
  assign lane_dp = 1'b0;
`endif

  always_comb begin
    oh  = 1'b1;
    idx = 2'd0;
    case (anode_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: oh  = 1'b0;
    endcase
  end

  always_comb begin
    ok  = 1'b1;
    val = 4'hF;
    case (seg_q)
      7'h40: val = 4'd0;
      7'h79: val = 4'd1;
      7'h24: val = 4'd2;
      7'h30: val = 4'd3;
      7'h19: val = 4'd4;
      7'h12: val = 4'd5;
      7'h02: val = 4'd6;
      7'h78: val = 4'd7;
      7'h00: val = 4'd8;
      7'h10: val = 4'd9;
      default: ok = 1'b0;
    endcase
  end

  // cnt counts the current cycle; capture fires on the cycle the count would reach SETTLE_CYCLES.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap     = 1'b0;
    start   = 1'b0;
    case (state)
      ST_IDLE: start = oh;
      ST_SETTLE: begin
        if (!oh)                  state_d = ST_IDLE;
        else if (!stable)         start   = 1'b1;
        else if (cnt == CNT_LAST) begin
          cap     = 1'b1;
          state_d = ST_HOLD;
        end else                  cnt_d   = cnt + 1'b1;
      end
      ST_HOLD: begin
        if (anode_q != anode_p) begin
          if (oh) start   = 1'b1;
          else    state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      if (SETTLE_CYCLES == 1) begin
        cap     = 1'b1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_SETTLE;
        cnt_d   = CW'(1);
      end
    end
  end

  always_comb begin
    if (cap)              tcnt_d = 32'd0;
    else if (tcnt == TMO) tcnt_d = TMO;
    else                  tcnt_d = tcnt + 32'd1;
    flush = !cap && (tcnt_d == TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tcnt      <= 32'd0;
      strobe_r  <= 1'b0;
      seg_err_r <= 1'b0;
      frame_r   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tcnt      <= tcnt_d;
      strobe_r  <= cap;
      seg_err_r <= cap && !ok;
      frame_r   <= &vld_nxt;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    seg7_digit_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (cap && (idx == 2'(k))),
      .flush     (flush),
      .ok        (ok),
      .val       (val),
      .dp        (lane_dp),
      .digit     (dig[k]),
      .valid     (vld[k]),
      .valid_nxt (vld_nxt[k]),
      .dp_cap    (dpc[k])
    );
  end

  assign bus.digits      = dig;
  assign bus.digit_valid = vld;
  assign bus.frame_valid = frame_r;
  assign bus.strobe      = strobe_r;
  assign bus.seg_err     = seg_err_r;
  assign bus.dp_out      = dpc;
endmodule
